updown_counter: RTL and testbench
=================================

# updown_counter

Parametrised synchronous up/down counter: the next-generation replacement for the 4-bit ripple counter built from `dff` cells. Single clock domain, configurable width and terminal value, parallel load, wrap or saturate mode, and a terminal-count pulse with sticky overflow flag. Used as the general-purpose event and period counter in the counter examples and as a timebase for downstream blocks.

## Interface

Parameters:
- WIDTH, 4, counter width in bits (≥ 2).
- MAX, 2**WIDTH-1, terminal value; count range is 0..MAX; MAX ≤ 2**WIDTH-1.
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rstb  input  1  synchronous reset, active-high (asserted = 1 despite suffix).
- in  input  1  count enable; one step per clk edge while high.
- dir  input  1  1 = count up, 0 = count down; sampled with `in`.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value loaded when `load` = 1.
- clr_ovf  input  1  clears sticky `ovf`.
- Q  output  WIDTH  current count, registered.
- tc  output  1  one-cycle registered pulse on a limit crossing.
- ovf  output  1  sticky flag, set on any limit crossing.
- cmp_val  input  WIDTH  compare value (only with COUNTER_CMP_EN).
- match  output  1  registered compare-match (only with COUNTER_CMP_EN).

## Operation

- Priority per edge: rstb > load > in. `dir` is ignored unless `in` = 1.
- rstb = 1: Q = 0, tc = 0, ovf = 0, match = 0.
- load = 1: Q = load_val, clamped to MAX if load_val > MAX. tc is not asserted; ovf is unchanged.
- in = 1, dir = 1: if Q < MAX, then Q + 1. If Q = MAX, Q = 0 (wrap) or holds MAX (saturate); tc = 1 for one cycle and ovf is set.
- in = 1, dir = 0: if Q > 0, then Q − 1. If Q = 0, Q = MAX (wrap) or holds 0 (saturate); tc = 1 for one cycle and ovf is set.
- In saturate mode, tc pulses on every enabled step attempted at the limit, not only on the first.
- in = 0 and load = 0: Q holds and tc = 0.
- Arithmetic is in WIDTH bits with no intermediate overflow. Comparisons are against MAX, not 2**WIDTH-1.
- ovf is cleared by clr_ovf. If a crossing and clr_ovf occur on the same edge, the set wins and ovf = 1.
- No state machine. The state is Q plus the tc, ovf and match flags.

## Timing

- All outputs are registered. Q, tc, ovf and match change only on a clk rising edge.
- Latency from inputs to Q is 1 cycle. tc asserts on the same edge Q takes its post-crossing value.
- A reset asserted mid-count takes effect on the next edge. The first count happens on the first edge after rstb is deasserted.
- Load and enable asserted together: load wins, no step is taken, and no tc is generated.
- There is no combinational path from inputs to outputs.

## Configuration

- Macro COUNTER_CMP_EN.
- Defined: the cmp_val and match ports exist. match is registered and equals 1 on the cycle where the updated Q equals cmp_val. It is evaluated against the next-state Q, so match coincides with Q == cmp_val. match is cleared by rstb.
- Undefined: the ports, the compare logic and the match register are all absent.
- The rest of the behaviour is identical in both builds.

## Test plan

- Reset: WIDTH=4, drive rstb=1 for 2 cycles with in=1 -> Q=0, tc=0, ovf=0. Then deassert rstb, in=1, dir=1 for 5 cycles -> Q=5.
- Wrap up: MAX=9, SATURATE=0, load 9 then in=1, dir=1 for 1 cycle -> Q=0, tc=1 for exactly 1 cycle, ovf=1. The next step gives Q=1 and tc=0.
- Wrap down and saturate: MAX=9, SATURATE=0, Q=0 with in=1, dir=0 -> Q=9, tc pulse. With SATURATE=1, Q=0 with 3 down steps -> Q stays 0, tc=1 on each of the 3 cycles.
- Priority: Q=3 with load=1, load_val=12, in=1 on the same edge, WIDTH=4, MAX=15 -> Q=12, tc=0. load_val=14 with MAX=10 -> Q=10.
- ovf race: on the same edge a wrap occurs and clr_ovf=1 -> ovf=1. On the next edge with clr_ovf=1 and no crossing -> ovf=0.
- Compare (COUNTER_CMP_EN): cmp_val=6, count up from 0 -> match=1 on exactly the cycle Q=6. Assert rstb mid-count -> match=0 and Q=0 on the next edge.

Source files
------------

// File: rtl/updown_counter.sv
// updown_counter: parametrised up/down counter with load, wrap/saturate, tc pulse and sticky ovf.
// Optional registered compare-match output enabled by macro COUNTER_CMP_EN.
module updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX      = 2**WIDTH-1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             in,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
`ifdef COUNTER_CMP_EN
  input  logic [WIDTH-1:0] cmp_val,
  output logic             match,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);
  localparam logic             SAT_V = SATURATE != 0;
  logic [WIDTH-1:0] q_q, q_d, step_v;
  logic             tc_q, tc_d, ovf_q, ovf_d, at_top, at_bot;
  always_comb begin
    at_top = q_q == MAX_V;
    at_bot = q_q == '0;
    step_v = dir ? (at_top ? (SAT_V ? MAX_V : '0) : q_q + ONE_V)
                 : (at_bot ? (SAT_V ? '0 : MAX_V) : q_q - ONE_V);
    // load overrides a step, so a crossing needs load low
    tc_d   = in && !load && (dir ? at_top : at_bot);
    q_d    = load ? (load_val > MAX_V ? MAX_V : load_val) : in ? step_v : q_q;
    ovf_d  = tc_d || (ovf_q && !clr_ovf);
  end
  always_ff @(posedge clk) begin
    if (rstb) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end
`ifdef COUNTER_CMP_EN
  logic match_q;
  always_ff @(posedge clk) begin
    if (rstb) match_q <= 1'b0;
    else match_q <= q_d == cmp_val;
  end
  assign match = match_q;
`endif
  assign Q   = q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed scoreboard bench over four counter configurations sharing one stimulus.
module tb_updown_counter;
  logic clk = 0, rstb = 1, in = 0, dir = 0, load = 0, clr_ovf = 0;
  logic [3:0] load_val = 0, cmp_val = 4'd6;
  logic [3:0] q_a, q_w, q_s, q_c;
  logic tc_a, tc_w, tc_s, tc_c, ovf_a, ovf_w, ovf_s, ovf_c;
  logic match_a;
  int checks = 0, errors = 0;
  typedef struct { int id; logic [5:0] exp; string tag; } entry_t;
  entry_t sb[$];
  always #5 clk = ~clk;
  updown_counter u_a (.clk(clk), .rstb(rstb), .in(in), .dir(dir), .load(load), .load_val(load_val),
`ifdef COUNTER_CMP_EN
    .cmp_val(cmp_val), .match(match_a),
`endif
    .clr_ovf(clr_ovf), .Q(q_a), .tc(tc_a), .ovf(ovf_a));
`ifndef COUNTER_CMP_EN
  assign match_a = 1'b0;
`endif
  updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(0)) u_w (.clk(clk), .rstb(rstb), .in(in), .dir(dir), .load(load),
`ifdef COUNTER_CMP_EN
    .cmp_val(cmp_val), .match(),
`endif
    .load_val(load_val), .clr_ovf(clr_ovf), .Q(q_w), .tc(tc_w), .ovf(ovf_w));
  updown_counter #(.WIDTH(4), .MAX(9), .SATURATE(1)) u_s (.clk(clk), .rstb(rstb), .in(in), .dir(dir), .load(load),
`ifdef COUNTER_CMP_EN
    .cmp_val(cmp_val), .match(),
`endif
    .load_val(load_val), .clr_ovf(clr_ovf), .Q(q_s), .tc(tc_s), .ovf(ovf_s));
  updown_counter #(.WIDTH(4), .MAX(10), .SATURATE(0)) u_c (.clk(clk), .rstb(rstb), .in(in), .dir(dir), .load(load),
`ifdef COUNTER_CMP_EN
    .cmp_val(cmp_val), .match(),
`endif
    .load_val(load_val), .clr_ovf(clr_ovf), .Q(q_c), .tc(tc_c), .ovf(ovf_c));

  function automatic logic [5:0] obs(int id);
    case (id)
      0: return {q_a, tc_a, ovf_a};
      1: return {q_w, tc_w, ovf_w};
      2: return {q_s, tc_s, ovf_s};
      3: return {q_c, tc_c, ovf_c};
      default: return {q_a, match_a, 1'b0};
    endcase
  endfunction
  // id 4 packs {Q, match, 0} of the default instance
  task automatic push(int id, logic [3:0] q, logic t, logic o, string tag);
    entry_t e;
    e.id = id; e.exp = {q, t, o}; e.tag = tag;
    sb.push_back(e);
  endtask
  task automatic tick();
    entry_t e;
    logic [5:0] got;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = obs(e.id);
      checks++;
      assert (got === e.exp) else begin
        errors++;
        $error("FAIL %s: got {q,tc,ovf}=%h expected %h", e.tag, got, e.exp);
      end
    end
  endtask
  task automatic drive(logic r, logic i, logic d, logic l, logic [3:0] lv, logic c);
    rstb = r; in = i; dir = d; load = l; load_val = lv; clr_ovf = c;
  endtask

  initial begin
    drive(1, 1, 1, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      push(0, 0, 0, 0, "reset_a");
      push(1, 0, 0, 0, "reset_w");
      tick();
    end
    drive(0, 1, 1, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      push(0, 4'(k), 0, 0, "count_up");
      tick();
    end
    drive(0, 0, 0, 1, 9, 0);
    push(1, 9, 0, 0, "load9_w"); push(2, 9, 0, 0, "load9_s");
    tick();
    drive(0, 1, 1, 0, 0, 0);
    push(1, 0, 1, 1, "wrap_up_w"); push(2, 9, 1, 1, "sat_up_s"); push(0, 10, 0, 0, "up_a");
    tick();
    push(1, 1, 0, 1, "after_wrap_w"); push(3, 0, 1, 1, "wrap_max10_c");
    tick();
    drive(0, 0, 0, 1, 0, 0);
    push(0, 0, 0, 0, "load0_a"); push(2, 0, 0, 1, "load0_s");
    tick();
    drive(0, 1, 0, 0, 0, 0);
    push(1, 9, 1, 1, "wrap_down_w"); push(2, 0, 1, 1, "sat_down1_s"); push(0, 15, 1, 1, "wrap_down_a");
    tick();
    push(2, 0, 1, 1, "sat_down2_s"); push(1, 8, 0, 1, "down_w");
    tick();
    push(2, 0, 1, 1, "sat_down3_s"); push(1, 7, 0, 1, "down2_w");
    tick();
    drive(0, 0, 0, 1, 3, 0);
    push(0, 3, 0, 1, "load3_a");
    tick();
    drive(0, 1, 1, 1, 12, 0);
    push(0, 12, 0, 1, "load_beats_in_a"); push(3, 10, 0, 1, "load_clamp12_c");
    tick();
    drive(0, 1, 0, 1, 14, 0);
    push(0, 14, 0, 1, "load14_a"); push(3, 10, 0, 1, "load_clamp14_c");
    tick();
    drive(0, 0, 1, 0, 0, 0);
    push(0, 14, 0, 1, "hold_a");
    tick();
    drive(0, 0, 0, 0, 0, 1);
    push(1, 9, 0, 0, "clr_ovf_w");
    tick();
    drive(0, 1, 1, 0, 0, 1);
    push(1, 0, 1, 1, "ovf_set_wins_w");
    tick();
    drive(0, 0, 0, 0, 0, 1);
    push(1, 0, 0, 0, "ovf_clr_after_w");
    tick();
    drive(1, 1, 1, 0, 0, 0);
    push(0, 0, 0, 0, "midcount_reset_a");
    tick();
    drive(0, 1, 1, 0, 0, 0);
    push(0, 1, 0, 0, "first_after_reset_a");
    tick();
`ifdef COUNTER_CMP_EN
    drive(1, 0, 0, 0, 0, 0);
    push(4, 0, 0, 0, "cmp_reset");
    tick();
    drive(0, 1, 1, 0, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      push(4, 4'(k), k == 6, 0, "cmp_match");
      tick();
    end
    drive(1, 1, 1, 0, 0, 0);
    push(4, 0, 0, 0, "cmp_midcount_reset");
    tick();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
